// File: rtl/multi_chan_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multi_chan_pulse_gen_pkg
// Purpose : Shared types and default widths for the multi-channel periodic
//           pulse generator and its per-channel engine.
// Ports   : none (package)
// Config  : PULSE_BURST_EN selects the burst-count feature in the users of
//           this package; the package itself is build-independent.
// Revision: 1.0  initial release
// ============================================================================
package multi_chan_pulse_gen_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int BURST_W_DEF = 4;

  typedef logic [CNT_W_DEF-1:0]   cnt_t;
  typedef logic [BURST_W_DEF-1:0] burst_t;

endpackage
`default_nettype wire

// File: rtl/pulse_gen_chan.sv
`default_nettype none
// ============================================================================
// Module  : pulse_gen_chan
// Purpose : One pulse-generator channel: shadow config, active config,
//           period counter, width compare, optional burst limiter.
// Ports   : clk, rst (async, active-high)
//           en        run enable (level); low pauses the count
//           sclr      synchronous clear of counter/outputs, config kept
//           cfg_load  capture period_in/width_in(/burst_in) into shadow
//           pulse     registered pulse output
//           wrap      registered strobe on the last cycle of each period
//           done      (PULSE_BURST_EN only) strobe on the final burst wrap
// Config  : macro PULSE_BURST_EN adds burst_in/done and the burst limiter.
// Revision: 1.0  initial release
// ============================================================================
module pulse_gen_chan
  import multi_chan_pulse_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF
`ifdef PULSE_BURST_EN
  ,parameter int BURST_W = BURST_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] width_in,
`ifdef PULSE_BURST_EN
  input  logic [BURST_W-1:0] burst_in,
  output logic               done,
`endif
  output logic             pulse,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] period_q, width_q, sh_period, sh_width, cnt_q;
  logic             sh_valid, pulse_q, wrap_q, stopped;
  logic [CNT_W-1:0] eff_width, thresh, new_period, new_width;
  logic             running, last, wrapping, apply;

  always_comb begin
    // Clamp width to the period so the threshold never underflows.
    eff_width  = (width_q > period_q) ? period_q : width_q;
    thresh     = period_q - eff_width;
    running    = en && (period_q != '0) && !stopped;
    last       = (cnt_q == period_q - ONE);
    wrapping   = running && last;
    // Idle channels take a pending shadow at once; running channels only at
    // a period boundary, where a same-cycle load is taken straight from the
    // inputs so it lands on this wrap rather than the next one.
    apply      = (sh_valid && !running) || (wrapping && (sh_valid || cfg_load));
    new_period = cfg_load ? period_in : sh_period;
    new_width  = cfg_load ? width_in  : sh_width;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q  <= '0;
      width_q   <= '0;
      sh_period <= '0;
      sh_width  <= '0;
      sh_valid  <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      if (cfg_load) begin
        sh_period <= period_in;
        sh_width  <= width_in;
      end
      if (sclr) begin
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
        wrap_q   <= 1'b0;
        sh_valid <= sh_valid | cfg_load;
      end else begin
        // Outputs reflect the count just consumed, so the Nth enabled edge
        // shows position N of the period.
        pulse_q <= running && (cnt_q >= thresh);
        wrap_q  <= wrapping;
        if (apply) begin
          period_q <= new_period;
          width_q  <= new_width;
          cnt_q    <= '0;
          sh_valid <= 1'b0;
        end else begin
          if (cfg_load) sh_valid <= 1'b1;
          if (running) cnt_q <= last ? '0 : cnt_q + ONE;
        end
      end
    end
  end

  assign pulse = pulse_q;
  assign wrap  = wrap_q;

`ifdef PULSE_BURST_EN
  localparam logic [BURST_W-1:0] BONE = BURST_W'(1);

  logic [BURST_W-1:0] burst_q, sh_burst, bcnt;
  logic               done_q, final_wrap;

  assign final_wrap = wrapping && (burst_q != '0) && (bcnt == burst_q - BONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q  <= '0;
      sh_burst <= '0;
      bcnt     <= '0;
      stopped  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (cfg_load) sh_burst <= burst_in;
      if (sclr) begin
        bcnt    <= '0;
        stopped <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= final_wrap;
        if (apply) begin
          burst_q <= cfg_load ? burst_in : sh_burst;
          bcnt    <= '0;
          stopped <= 1'b0;
        end else if (!en) begin
          // Dropping the enable re-arms a finished burst.
          bcnt    <= '0;
          stopped <= 1'b0;
        end else if (final_wrap) begin
          bcnt    <= '0;
          stopped <= 1'b1;
        end else if (wrapping && (burst_q != '0)) begin
          bcnt <= bcnt + BONE;
        end
      end
    end
  end

  assign done = done_q;
`else
  assign stopped = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/multi_chan_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module  : multi_chan_pulse_gen
// Purpose : NUM_CH independent programmable periodic pulse generators.
// Ports   : clk, rst (async, active-high)
//           en_i[NUM_CH]        per-channel run enable
//           sclr_i              synchronous clear of all counters
//           cfg_load_i[NUM_CH]  per-channel shadow capture strobe
//           period_i/width_i    packed CNT_W slices, ch k at [k*CNT_W +: CNT_W]
//           pulse_o[NUM_CH]     registered pulses
//           wrap_o[NUM_CH]      last-cycle-of-period strobes
//           burst_i/done_o      only with PULSE_BURST_EN
// Config  : macro PULSE_BURST_EN enables burst-limited operation.
// Revision: 1.0  initial release
// ============================================================================
module multi_chan_pulse_gen
  import multi_chan_pulse_gen_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = CNT_W_DEF
`ifdef PULSE_BURST_EN
  ,parameter int BURST_W = BURST_W_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic                    sclr_i,
  input  logic [NUM_CH-1:0]       cfg_load_i,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH*CNT_W-1:0] width_i,
`ifdef PULSE_BURST_EN
  input  logic [NUM_CH*BURST_W-1:0] burst_i,
  output logic [NUM_CH-1:0]         done_o,
`endif
  output logic [NUM_CH-1:0]       pulse_o,
  output logic [NUM_CH-1:0]       wrap_o
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pulse_gen_chan #(
      .CNT_W     (CNT_W)
`ifdef PULSE_BURST_EN
      ,.BURST_W  (BURST_W)
`endif
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en_i[k]),
      .sclr      (sclr_i),
      .cfg_load  (cfg_load_i[k]),
      .period_in (period_i[k*CNT_W +: CNT_W]),
      .width_in  (width_i[k*CNT_W +: CNT_W]),
`ifdef PULSE_BURST_EN
      .burst_in  (burst_i[k*BURST_W +: BURST_W]),
      .done      (done_o[k]),
`endif
      .pulse     (pulse_o[k]),
      .wrap      (wrap_o[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_chan_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_multi_chan_pulse_gen
// Purpose : Self-checking bench for multi_chan_pulse_gen: directed vector
//           table, multi-cycle corner sequences, randomized traffic against
//           a behavioural model (burst check only with PULSE_BURST_EN).
// Revision: 1.0  initial release
// ============================================================================
module tb_multi_chan_pulse_gen;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    en_i, cfg_load_i, pulse_o, wrap_o;
  logic              sclr_i;
  logic [NCH*CW-1:0] period_i, width_i;
`ifdef PULSE_BURST_EN
  logic [NCH*4-1:0]  burst_i;
  logic [NCH-1:0]    done_o;
`endif

  multi_chan_pulse_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .sclr_i     (sclr_i),
    .cfg_load_i (cfg_load_i),
    .period_i   (period_i),
    .width_i    (width_i),
`ifdef PULSE_BURST_EN
    .burst_i    (burst_i),
    .done_o     (done_o),
`endif
    .pulse_o    (pulse_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  bit model_on = 1'b0;

  // Behavioural model: position within the period counted in enabled cycles;
  // the pulse occupies the last min(W,P) positions, wrap the final one.
  int mP[NCH], mW[NCH], sP[NCH], sW[NCH], mpos[NCH];
  bit msv[NCH], mpul[NCH], mwrp[NCH];
  int m_p, m_wc;
  bit m_ld, m_run, m_end;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        mP[k] = 0; mW[k] = 0; sP[k] = 0; sW[k] = 0; mpos[k] = 0;
        msv[k] = 0; mpul[k] = 0; mwrp[k] = 0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        m_p   = mP[k];
        m_wc  = (mW[k] < m_p) ? mW[k] : m_p;
        m_ld  = cfg_load_i[k];
        m_run = en_i[k] && (m_p > 0);
        m_end = m_run && (mpos[k] + 1 == m_p);
        if (m_ld) begin
          sP[k] = int'(period_i[k*CW +: CW]);
          sW[k] = int'(width_i[k*CW +: CW]);
        end
        if (sclr_i) begin
          mpos[k] = 0; mpul[k] = 0; mwrp[k] = 0;
          if (m_ld) msv[k] = 1;
        end else begin
          mpul[k] = m_run && (mpos[k] + 1 > m_p - m_wc);
          mwrp[k] = m_end;
          if (m_run) mpos[k] = m_end ? 0 : mpos[k] + 1;
          if ((m_end || !m_run) && (msv[k] || (m_end && m_ld))) begin
            mP[k] = sP[k]; mW[k] = sW[k]; mpos[k] = 0; msv[k] = 0;
          end else if (m_ld) begin
            msv[k] = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (model_on) begin
      for (int k = 0; k < NCH; k++) begin
        chk($sformatf("model_pulse_ch%0d", k), 32'(pulse_o[k]), 32'(mpul[k]));
        chk($sformatf("model_wrap_ch%0d", k), 32'(wrap_o[k]), 32'(mwrp[k]));
      end
    end
  endtask

  task automatic set_cfg(input int ch, input int p, input int w);
    period_i[ch*CW +: CW] = CW'(p);
    width_i[ch*CW +: CW]  = CW'(w);
  endtask

  task automatic load(input int ch, input int p, input int w);
    set_cfg(ch, p, w);
    cfg_load_i[ch] = 1'b1;
    tick();
    cfg_load_i[ch] = 1'b0;
  endtask

  typedef struct {
    int   ch;
    int   p;
    int   w;
    int   cyc;
    logic exp_pulse;
    logic exp_wrap;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input vec_t v);
    en_i = '0;
    load(v.ch, v.p, v.w);
    tick();                       // idle channel adopts shadow here
    en_i[v.ch] = 1'b1;
    repeat (v.cyc) tick();
    chk($sformatf("vec_pulse ch%0d P%0d W%0d c%0d", v.ch, v.p, v.w, v.cyc),
        32'(pulse_o[v.ch]), 32'(v.exp_pulse));
    chk($sformatf("vec_wrap ch%0d P%0d W%0d c%0d", v.ch, v.p, v.w, v.cyc),
        32'(wrap_o[v.ch]), 32'(v.exp_wrap));
    en_i[v.ch] = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0, 10, 1,  9, 1'b0, 1'b0};
    vecs[1]  = '{0, 10, 1, 10, 1'b1, 1'b1};
    vecs[2]  = '{0, 10, 1, 20, 1'b1, 1'b1};
    vecs[3]  = '{0, 10, 1, 30, 1'b1, 1'b1};
    vecs[4]  = '{0, 10, 1, 31, 1'b0, 1'b0};
    vecs[5]  = '{0, 10, 1, 35, 1'b0, 1'b0};
    vecs[6]  = '{1,  8, 3,  5, 1'b0, 1'b0};
    vecs[7]  = '{1,  8, 3,  6, 1'b1, 1'b0};
    vecs[8]  = '{1,  8, 3,  8, 1'b1, 1'b1};
    vecs[9]  = '{1,  8, 3,  9, 1'b0, 1'b0};
    vecs[10] = '{1,  8, 0,  8, 1'b0, 1'b1};
    vecs[11] = '{1,  8, 12, 1, 1'b1, 1'b0};
    vecs[12] = '{1,  8, 12, 8, 1'b1, 1'b1};

    rst = 1'b1; en_i = '0; sclr_i = 1'b0; cfg_load_i = '0;
    period_i = '0; width_i = '0;
`ifdef PULSE_BURST_EN
    burst_i = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pulse", 32'(pulse_o), 32'(0));
    chk("reset_wrap", 32'(wrap_o), 32'(0));
    rst = 1'b0;
    model_on = 1'b1;

    // Directed vector table
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reconfigure mid-period: current period completes, then new period
    en_i = '0;
    load(2, 10, 2);
    tick();
    en_i[2] = 1'b1;
    repeat (4) tick();
    set_cfg(2, 5, 1);
    cfg_load_i[2] = 1'b1;
    tick();
    cfg_load_i[2] = 1'b0;
    repeat (4) tick();
    chk("recfg_wrap_c9", 32'(wrap_o[2]), 32'(0));
    tick();
    chk("recfg_wrap_c10", 32'(wrap_o[2]), 32'(1));
    chk("recfg_pulse_c10", 32'(pulse_o[2]), 32'(1));
    repeat (4) tick();
    chk("recfg_wrap_c14", 32'(wrap_o[2]), 32'(0));
    chk("recfg_pulse_c14", 32'(pulse_o[2]), 32'(0));
    tick();
    chk("recfg_wrap_c15", 32'(wrap_o[2]), 32'(1));
    chk("recfg_pulse_c15", 32'(pulse_o[2]), 32'(1));
    repeat (5) tick();
    chk("recfg_wrap_c20", 32'(wrap_o[2]), 32'(1));

    // Pause at cnt=6 for 4 cycles, then resume from held count
    en_i = '0;
    load(3, 10, 1);
    tick();
    en_i[3] = 1'b1;
    repeat (6) tick();
    en_i[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pause_pulse", 32'(pulse_o[3]), 32'(0));
      chk("pause_wrap", 32'(wrap_o[3]), 32'(0));
    end
    en_i[3] = 1'b1;
    repeat (3) tick();
    chk("resume_wrap_early", 32'(wrap_o[3]), 32'(0));
    tick();
    chk("resume_wrap", 32'(wrap_o[3]), 32'(1));
    chk("resume_pulse", 32'(pulse_o[3]), 32'(1));

    // sclr and asynchronous rst mid-period on all channels
    en_i = '0;
    for (int k = 0; k < NCH; k++) set_cfg(k, 10, 10);
    cfg_load_i = '1;
    tick();
    cfg_load_i = '0;
    tick();
    en_i = '1;
    repeat (3) tick();
    chk("const_high_all", 32'(pulse_o), 32'hF);
    sclr_i = 1'b1;
    tick();
    chk("sclr_pulse", 32'(pulse_o), 32'(0));
    chk("sclr_wrap", 32'(wrap_o), 32'(0));
    sclr_i = 1'b0;
    repeat (9) tick();
    chk("sclr_restart_nowrap", 32'(wrap_o), 32'(0));
    chk("sclr_cfg_kept", 32'(pulse_o), 32'hF);
    tick();
    chk("sclr_restart_wrap", 32'(wrap_o), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pulse", 32'(pulse_o), 32'(0));
    chk("async_rst_wrap", 32'(wrap_o), 32'(0));
    #2 rst = 1'b0;
    repeat (12) tick();
    chk("rst_cfg_cleared_pulse", 32'(pulse_o), 32'(0));
    chk("rst_cfg_cleared_wrap", 32'(wrap_o), 32'(0));

    // Randomized traffic against the model
    for (int t = 0; t < 2000; t++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 19) == 0) en_i[k] = ~en_i[k];
        cfg_load_i[k] = ($urandom_range(0, 24) == 0);
        set_cfg(k, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)),
                int'($urandom_range(0, 14)));
      end
      sclr_i = ($urandom_range(0, 99) == 0);
      tick();
    end
    cfg_load_i = '0;
    sclr_i = 1'b0;

`ifdef PULSE_BURST_EN
    // Burst of 3 periods, then silent until enable toggles
    model_on = 1'b0;
    en_i = '0;
    tick();
    burst_i[3:0] = 4'd3;
    load(0, 4, 1);
    tick();
    en_i[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("burst_pulse_c%0d", c), 32'(pulse_o[0]), 32'((c % 4 == 0) && (c <= 12)));
      chk($sformatf("burst_done_c%0d", c), 32'(done_o[0]), 32'(c == 12));
    end
    en_i[0] = 1'b0;
    tick();
    en_i[0] = 1'b1;
    repeat (4) tick();
    chk("burst_rearm_pulse", 32'(pulse_o[0]), 32'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
